// File: rtl/camera_pattern_gen.sv
// Parallel camera sensor emulator: pixel_clk, lv/fv timing and Bayer BGGR test patterns
// (solid, colour bars, ramp, checkerboard), with outputs changing on falling pixel_clk edges.
module camera_pattern_gen #(
  parameter int unsigned HSIZE    = 'd1288,
  parameter int unsigned VSIZE    = 'd968,
  parameter int unsigned HBLANK   = 'd64,
  parameter int unsigned FV_LEAD  = 'd8,
  parameter int unsigned FV_TRAIL = 'd8,
  parameter int unsigned VBLANK   = 'd256,
  parameter int unsigned CLK_DIV  = 'd2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [29:0] solid_rgb,
  output logic        pixel_clk,
  output logic [9:0]  pixel_data,
  output logic        lv,
  output logic        fv,
  output logic        frame_done
);

  localparam int unsigned M1   = (HSIZE > HBLANK) ? HSIZE : HBLANK;
  localparam int unsigned M2   = (FV_LEAD > FV_TRAIL) ? FV_LEAD : FV_TRAIL;
  localparam int unsigned M3   = (M1 > M2) ? M1 : M2;
  localparam int unsigned MAXD = (M3 > VBLANK) ? M3 : VBLANK;
  localparam int unsigned CW   = $clog2(MAXD + 1);
  localparam int unsigned YW   = $clog2(VSIZE + 1);
  localparam int unsigned DW   = $clog2(CLK_DIV);
  localparam int unsigned BAR_W = HSIZE / 8;
  localparam int unsigned BW   = $clog2(BAR_W + 1);

  typedef enum logic [2:0] {IDLE, LEAD, ACTIVE, HBL, TRAIL, VBL} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic [CW-1:0]   cnt;
  logic [YW-1:0]   y;
  logic [15:0]     frame_cnt;
  logic [BW-1:0]   bar_cnt;
  logic [2:0]      bar_idx;
  logic [1:0]      pat_q;
  logic [29:0]     rgb_q;
  logic            fv_d, lv_d;
  logic [9:0]      pix, pix_d;
  logic [9:0]      comp_r, comp_g, comp_b;
  logic            sel_b, sel_r, y3;

  // tick marks the clk cycle in which pixel_clk falls; all pixel-rate state advances there
  assign tick = pixel_clk && (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      pixel_clk <= 1'b0;
    end else if (div_cnt == DW'(CLK_DIV - 1)) begin
      div_cnt   <= '0;
      pixel_clk <= ~pixel_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else if (tick) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fv_d      = 1'b0;
    lv_d      = 1'b0;
    pix_d     = '0;
    unique case (state)
      IDLE:   if (enable) state_nxt = LEAD;
      LEAD: begin
        fv_d = 1'b1;
        if (cnt == CW'(FV_LEAD - 1)) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        fv_d  = 1'b1;
        lv_d  = 1'b1;
        pix_d = pix;
        if (cnt == CW'(HSIZE - 1)) state_nxt = (y == YW'(VSIZE - 1)) ? TRAIL : HBL;
      end
      HBL: begin
        fv_d = 1'b1;
        if (cnt == CW'(HBLANK - 1)) state_nxt = ACTIVE;
      end
      TRAIL: begin
        fv_d = 1'b1;
        if (cnt == CW'(FV_TRAIL - 1)) state_nxt = VBL;
      end
      VBL:    if (cnt == CW'(VBLANK - 1)) state_nxt = enable ? LEAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bayer BGGR: B at even/even, R at odd/odd, G elsewhere
  always_comb begin
    sel_b  = ~y[0] & ~cnt[0];
    sel_r  = y[0] & cnt[0];
    y3     = |(y & YW'(8));
    comp_r = rgb_q[29:20];
    comp_g = rgb_q[19:10];
    comp_b = rgb_q[9:0];
    pix    = '0;
    if (pat_q == 2'd1) begin
      comp_r = {10{~bar_idx[1]}};
      comp_g = {10{~bar_idx[2]}};
      comp_b = {10{~bar_idx[0]}};
    end
    unique case (pat_q)
      2'd2:    pix = 10'(cnt) + 10'(y) + frame_cnt[9:0];
      2'd3:    pix = {10{cnt[3] ^ y3}};
      default: pix = sel_b ? comp_b : (sel_r ? comp_r : comp_g);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fv         <= 1'b0;
      lv         <= 1'b0;
      pixel_data <= '0;
      frame_done <= 1'b0;
      cnt        <= '0;
      y          <= '0;
      frame_cnt  <= '0;
      bar_cnt    <= '0;
      bar_idx    <= '0;
      pat_q      <= '0;
      rgb_q      <= '0;
    end else begin
      frame_done <= tick && fv && !fv_d;
      if (tick) begin
        fv         <= fv_d;
        lv         <= lv_d;
        pixel_data <= pix_d;
        cnt        <= (state_nxt != state) ? '0 : cnt + 1'b1;
        if (state_nxt == LEAD && state != LEAD) begin
          y     <= '0;
          pat_q <= pattern_sel;
          rgb_q <= solid_rgb;
        end
        if (state == ACTIVE && state_nxt == HBL) y <= y + 1'b1;
        if (state == TRAIL && state_nxt == VBL) frame_cnt <= frame_cnt + 1'b1;
        // bar counter replaces x/(HSIZE/8); index holds at 7 for any remainder pixels
        if (state_nxt == ACTIVE && state != ACTIVE) begin
          bar_cnt <= '0;
          bar_idx <= '0;
        end else if (state == ACTIVE) begin
          if (bar_cnt == BW'(BAR_W - 1)) begin
            bar_cnt <= '0;
            if (bar_idx != 3'd7) bar_idx <= bar_idx + 1'b1;
          end else begin
            bar_cnt <= bar_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_pattern_gen.sv
// Self-checking bench for camera_pattern_gen: frame-level reference model, vector table,
// randomized pattern changes, enable-drop and mid-line reset sequences.
module tb_camera_pattern_gen;

  localparam int H = 16, V = 4, HB = 2, FL = 1, FT = 1, VB = 3, CD = 2;
  localparam int LINE = H + HB;
  localparam int PF = FL + V * LINE - HB + FT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [29:0] solid_rgb;
  logic        pixel_clk;
  logic [9:0]  pixel_data;
  logic        lv, fv, frame_done;

  camera_pattern_gen #(
    .HSIZE(H), .VSIZE(V), .HBLANK(HB), .FV_LEAD(FL), .FV_TRAIL(FT), .VBLANK(VB), .CLK_DIV(CD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .pixel_clk(pixel_clk), .pixel_data(pixel_data),
    .lv(lv), .fv(fv), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] pix(input int pat, input logic [29:0] rgb,
                                     input int x, input int y, input int fc);
    logic [9:0] r, g, b;
    logic [2:0] c;
    int bar;
    r = rgb[29:20];
    g = rgb[19:10];
    b = rgb[9:0];
    if (pat == 2) return 10'((x + y + fc) % 1024);
    if (pat == 3) return (((x / 8) % 2) != ((y / 8) % 2)) ? 10'h3FF : 10'h000;
    if (pat == 1) begin
      bar = x / (H / 8);
      if (bar > 7) bar = 7;
      case (bar)
        0: c = 3'b111;  1: c = 3'b110;  2: c = 3'b011;  3: c = 3'b010;
        4: c = 3'b101;  5: c = 3'b100;  6: c = 3'b001;  default: c = 3'b000;
      endcase
      r = {10{c[2]}};
      g = {10{c[1]}};
      b = {10{c[0]}};
    end
    if (y % 2 == 0 && x % 2 == 0) return b;
    if (y % 2 == 1 && x % 2 == 1) return r;
    return g;
  endfunction

  // Expected {fv,lv,data} for period p of a frame, counted from the first fv-high period
  function automatic void exp_sample(input int p, input int pat, input logic [29:0] rgb,
                                     input int fc, output logic [11:0] e,
                                     output int x, output int y, output bit act);
    int q, off;
    act = 1'b0; x = 0; y = 0;
    e = {2'b10, 10'h000};
    if (p >= FL && p < PF - FT) begin
      q = p - FL;
      y = q / LINE;
      off = q % LINE;
      if (off < H) begin
        act = 1'b1;
        x = off;
        e = {2'b11, pix(pat, rgb, x, y, fc)};
      end
    end
  endfunction

  int          p = 0, frame_no = 0, zero_run = 0, rises = 0, mon_line = -1, cur_pat = 0;
  bit          in_frame = 0, first_after_rst = 1, en_all = 0;
  logic        prev_pclk = 0, prev_fv = 0, prev_rstn = 0;
  logic [11:0] prev_out = '0, cur, e;
  logic [29:0] cur_rgb = '0;
  logic [9:0]  cap [8][V][H];

  always @(posedge clk) begin
    int ex, ey;
    bit act;
    #1;
    if (!reset_n) begin
      in_frame = 0; frame_no = 0; rises = 0; first_after_rst = 1; zero_run = 0;
      en_all = 0; mon_line = -1;
    end else begin
      cur = {fv, lv, pixel_data};
      if (prev_rstn && cur != prev_out) chk("stable_edge", 32'({prev_pclk, pixel_clk}), 32'b10);
      if (prev_rstn && (frame_done || (prev_fv && !fv)))
        chk("frame_done", 32'(frame_done), 32'(prev_fv && !fv));
      if (!enable) en_all = 0;
      if (!prev_pclk && pixel_clk) begin
        rises++;
        if (!in_frame && fv) begin
          if (first_after_rst) chk("start_latency", 32'(rises), 32'd3);
          else if (en_all) chk("vblank_gap", 32'(zero_run), 32'(VB));
          else chk("idle_gap_min", 32'(zero_run >= VB), 32'd1);
          in_frame = 1; p = 0; mon_line = -1; first_after_rst = 0;
          cur_pat = int'(pattern_sel); cur_rgb = solid_rgb;
        end
        if (in_frame) begin
          exp_sample(p, cur_pat, cur_rgb, frame_no, e, ex, ey, act);
          chk("sample", 32'(cur), 32'(e));
          if (act) begin
            mon_line = ey;
            if (frame_no < 8) cap[frame_no][ey][ex] = pixel_data;
          end
          p++;
          if (p == PF) begin
            in_frame = 0; frame_no++; zero_run = 0; en_all = 1;
          end
        end else begin
          chk("idle_out", 32'(cur), 32'd0);
          zero_run++;
        end
      end
    end
    prev_pclk = pixel_clk;
    prev_out  = {fv, lv, pixel_data};
    prev_fv   = fv;
    prev_rstn = reset_n;
  end

  task automatic wait_frame_line(input int fn, input int ln);
    int n = 0;
    while (!(frame_no == fn && in_frame && mon_line == ln && lv) && n < 4000) begin
      @(posedge clk); #2; n++;
    end
    chk("wait_line", 32'(n < 4000), 32'd1);
  endtask

  task automatic wait_frames(input int fn);
    int n = 0;
    while (frame_no < fn && n < 4000) begin
      @(posedge clk); #2; n++;
    end
    chk("wait_frames", 32'(n < 4000), 32'd1);
  endtask

  typedef struct {
    int         f;
    int         y;
    int         x;
    logic [9:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int n;
    tbl = '{
      '{0, 0, 0, 10'h0AA}, '{0, 0, 1, 10'h155}, '{0, 0, 2, 10'h0AA},
      '{0, 1, 0, 10'h155}, '{0, 1, 1, 10'h3FF}, '{0, 1, 2, 10'h155},
      '{1, 0, 0, 10'h3FF}, '{1, 0, 1, 10'h3FF}, '{1, 0, 14, 10'h000}, '{1, 0, 15, 10'h000},
      '{1, 1, 2, 10'h3FF}, '{1, 0, 10, 10'h000}, '{1, 1, 11, 10'h3FF},
      '{2, 1, 0, 10'h003}, '{2, 3, 15, 10'h014},
      '{3, 0, 8, 10'h3FF}, '{3, 0, 0, 10'h000}, '{3, 3, 8, 10'h3FF}
    };

    reset_n = 1'b0;
    enable = 1'b1;
    pattern_sel = 2'd0;
    solid_rgb = {10'h3FF, 10'h155, 10'h0AA};
    repeat (4) @(posedge clk);
    #2;
    chk("rst_outs", 32'({pixel_clk, pixel_data, lv, fv, frame_done}), 32'd0);
    reset_n = 1'b1;

    // frames 0..3: solid, bars, ramp, checker; each change lands mid-frame
    wait_frame_line(0, 1); pattern_sel = 2'd1;
    wait_frame_line(1, 1); pattern_sel = 2'd2;
    wait_frame_line(2, 1); pattern_sel = 2'd3;
    wait_frames(4);
    for (int i = 0; i < tbl.size(); i++)
      chk($sformatf("vec%0d_f%0d_y%0d_x%0d", i, tbl[i].f, tbl[i].y, tbl[i].x),
          32'(cap[tbl[i].f][tbl[i].y][tbl[i].x]), 32'(tbl[i].exp));

    for (int i = 0; i < 6; i++) begin
      wait_frame_line(4 + i, 2);
      pattern_sel = 2'($urandom_range(0, 3));
      solid_rgb = 30'($urandom);
    end
    wait_frames(10);

    // enable dropped during line 2: frame finishes, then the generator parks
    wait_frame_line(10, 2);
    enable = 1'b0;
    wait_frames(11);
    repeat (600) @(posedge clk);
    #2;
    chk("idle_fv", 32'(fv), 32'd0);
    chk("idle_frames", 32'(frame_no), 32'd11);
    chk("idle_in_frame", 32'(in_frame), 32'd0);
    enable = 1'b1;
    n = 0;
    while (!in_frame && n < 200) begin @(posedge clk); #2; n++; end
    chk("restart", 32'(in_frame), 32'd1);

    // reset pulsed mid-line: outputs clear at once, next frame restarts from frame_cnt=0
    pattern_sel = 2'd2;
    wait_frame_line(12, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outs", 32'({pixel_clk, pixel_data, lv, fv, frame_done}), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    wait_frames(1);
    chk("post_rst_y0x0", 32'(cap[0][0][0]), 32'h000);
    chk("post_rst_y1x0", 32'(cap[0][1][0]), 32'h001);
    chk("post_rst_y3x15", 32'(cap[0][3][15]), 32'h012);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
